// File: rtl/z_result_unit_if.sv
// Beat stream from the Z capture stage to the 32-bit bus: valid/ready with a
// flag marking the ZHi beat.
interface z_result_unit_if;
  localparam int unsigned DATA_W = 32;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_hi;

  modport master (output out_valid, output out_data, output out_hi, input out_ready);
  modport slave  (input out_valid, input out_data, input out_hi, output out_ready);
endinterface

// File: rtl/z_result_unit.sv
// Z capture stage: latches the 64-bit ALU result, updates HI/LO on wide ops,
// and drains ZLo (then ZHi for wide ops) onto the bus under valid/ready.
module z_result_unit (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    z_in,
  input  logic [63:0]             result,
  input  logic                    op_wide,
  z_result_unit_if.master         out_bus,
  output logic                    busy,
  output logic [31:0]             hi_q,
  output logic [31:0]             lo_q,
  output logic                    overrun
);

  localparam int unsigned RES_W = 64;
  localparam int unsigned BUS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BUS_W-1:0]   r_zhi;
  logic [BUS_W-1:0]   r_zlo;
  logic [BUS_W-1:0]   r_hi;
  logic [BUS_W-1:0]   r_lo;
  logic               r_wide;
  logic               r_overrun;
  logic               w_idle;
  logic               w_capture;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_capture = z_in & w_idle;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (z_in) w_state_nxt = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (out_bus.out_ready) w_state_nxt = r_wide ? ST_SEND_HI : ST_IDLE;
      end
      ST_SEND_HI: begin
        if (out_bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Z and HI/LO load only from IDLE; a strobe while busy just flags overrun.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_zhi     <= '0;
      r_zlo     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_wide    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_capture) begin
        r_zhi  <= result[RES_W-1:BUS_W];
        r_zlo  <= result[BUS_W-1:0];
        r_wide <= op_wide;
        if (op_wide) begin
          r_hi <= result[RES_W-1:BUS_W];
          r_lo <= result[BUS_W-1:0];
        end
      end
      if (z_in && !w_idle) r_overrun <= 1'b1;
    end
  end

  // Bus outputs decode straight from state so reset drops them immediately.
  assign out_bus.out_valid = !w_idle;
  assign out_bus.out_hi    = (r_state == ST_SEND_HI);
  assign out_bus.out_data  = (r_state == ST_SEND_LO) ? r_zlo :
                             (r_state == ST_SEND_HI) ? r_zhi : '0;

  assign busy    = !w_idle;
  assign hi_q    = r_hi;
  assign lo_q    = r_lo;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_z_result_unit.sv
// Bench for z_result_unit: directed vector table, reset-abort sequence, and
// randomized traffic against a beat-queue reference model.
module tb_z_result_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        z_in;
  logic [63:0] result;
  logic        op_wide;
  logic        busy;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        overrun;

  z_result_unit_if bus ();

  z_result_unit dut (
    .clock   (clock),
    .clear   (clear),
    .z_in    (z_in),
    .result  (result),
    .op_wide (op_wide),
    .out_bus (bus),
    .busy    (busy),
    .hi_q    (hi_q),
    .lo_q    (lo_q),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        z;
    logic        w;
    logic [63:0] res;
    logic        rdy;
    logic        v;
    logic [31:0] d;
    logic        h;
    logic [31:0] hq;
    logic [31:0] lq;
    logic        ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic z, logic w, logic [63:0] res, logic rdy,
                              logic v, logic [31:0] d, logic h,
                              logic [31:0] hq, logic [31:0] lq, logic ov);
    vec_t t;
    t.z = z; t.w = w; t.res = res; t.rdy = rdy;
    t.v = v; t.d = d; t.h = h; t.hq = hq; t.lq = lq; t.ov = ov;
    return t;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        h;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_ov;

  task automatic do_reset();
    @(negedge clock);
    clear = 1'b0;
    z_in  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    mq.delete();
    m_hi = '0;
    m_lo = '0;
    m_ov = 1'b0;
  endtask

  initial begin
    clear = 1'b0;
    z_in = 1'b0;
    op_wide = 1'b0;
    result = '0;
    bus.out_ready = 1'b0;
    #1;
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy",  64'(busy), 64'd0);
    check("reset_hi_q",  64'(hi_q), 64'd0);
    check("reset_lo_q",  64'(lo_q), 64'd0);
    check("reset_ovr",   64'(overrun), 64'd0);
    @(negedge clock);
    clear = 1'b1;

    // Inputs for one edge, then the outputs expected after that edge.
    tbl.push_back(mk(1, 0, 64'h00000000_00000011, 1, 1, 32'h00000011, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 64'h0,                 1, 0, 32'h0,        0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 64'h0000FFFF_0000F000, 0, 1, 32'h0000F000, 0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(0, 0, 64'h0,                 0, 1, 32'h0000F000, 0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(0, 0, 64'h0,                 0, 1, 32'h0000F000, 0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(0, 0, 64'h0,                 1, 1, 32'h0000FFFF, 1, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(0, 0, 64'h0,                 1, 0, 32'h0,        0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(1, 0, 64'h12345678_9ABCDEF0, 1, 1, 32'h9ABCDEF0, 0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(0, 0, 64'h0,                 1, 0, 32'h0,        0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(1, 0, 64'hAAAAAAAA_00000001, 1, 1, 32'h00000001, 0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(0, 0, 64'h0,                 1, 0, 32'h0,        0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(1, 0, 64'hBBBBBBBB_00000002, 1, 1, 32'h00000002, 0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(0, 0, 64'h0,                 1, 0, 32'h0,        0, 32'h0000FFFF, 32'h0000F000, 0));
    tbl.push_back(mk(1, 1, 64'h11112222_33334444, 0, 1, 32'h33334444, 0, 32'h11112222, 32'h33334444, 0));
    tbl.push_back(mk(1, 1, 64'hDEADBEEF_DEADBEEF, 0, 1, 32'h33334444, 0, 32'h11112222, 32'h33334444, 1));
    tbl.push_back(mk(0, 0, 64'h0,                 1, 1, 32'h11112222, 1, 32'h11112222, 32'h33334444, 1));
    tbl.push_back(mk(0, 0, 64'h0,                 1, 0, 32'h0,        0, 32'h11112222, 32'h33334444, 1));
    tbl.push_back(mk(0, 0, 64'h0,                 0, 0, 32'h0,        0, 32'h11112222, 32'h33334444, 1));

    foreach (tbl[i]) begin
      z_in = tbl[i].z;
      op_wide = tbl[i].w;
      result = tbl[i].res;
      bus.out_ready = tbl[i].rdy;
      @(negedge clock);
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].v));
      check($sformatf("vec%0d_busy", i),  64'(busy), 64'(tbl[i].v));
      if (tbl[i].v) begin
        check($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(tbl[i].d));
        check($sformatf("vec%0d_hi", i),   64'(bus.out_hi), 64'(tbl[i].h));
      end
      check($sformatf("vec%0d_hi_q", i), 64'(hi_q), 64'(tbl[i].hq));
      check($sformatf("vec%0d_lo_q", i), 64'(lo_q), 64'(tbl[i].lq));
      check($sformatf("vec%0d_ovr", i),  64'(overrun), 64'(tbl[i].ov));
    end

    // Abort during SEND_HI: everything must drop before the next edge.
    z_in = 1'b1; op_wide = 1'b1; result = 64'hCAFEF00D_01234567; bus.out_ready = 1'b1;
    @(negedge clock);
    z_in = 1'b0;
    @(negedge clock);
    check("pre_abort_hi", 64'(bus.out_hi), 64'd1);
    check("pre_abort_data", 64'(bus.out_data), 64'hCAFEF00D);
    bus.out_ready = 1'b0;
    #2 clear = 1'b0;
    #1;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy",  64'(busy), 64'd0);
    check("abort_hi_q",  64'(hi_q), 64'd0);
    check("abort_lo_q",  64'(lo_q), 64'd0);
    check("abort_ovr",   64'(overrun), 64'd0);
    z_in = 1'b1;
    @(negedge clock);
    check("zin_in_reset_busy", 64'(busy), 64'd0);
    z_in = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    check("post_reset_idle", 64'(busy), 64'd0);
    check("post_reset_ovr", 64'(overrun), 64'd0);

    // Randomized traffic against the beat-queue model, reset every block.
    for (int blk = 0; blk < 10; blk++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        logic        z;
        logic        w;
        logic        rdy;
        logic [63:0] res;
        int          pre;
        logic        mv;
        mv = (mq.size() > 0);
        check("rnd_valid", 64'(bus.out_valid), 64'(mv));
        check("rnd_busy",  64'(busy), 64'(mv));
        if (mv) begin
          check("rnd_data", 64'(bus.out_data), 64'(mq[0].d));
          check("rnd_hi",   64'(bus.out_hi), 64'(mq[0].h));
        end
        check("rnd_hi_q", 64'(hi_q), 64'(m_hi));
        check("rnd_lo_q", 64'(lo_q), 64'(m_lo));
        check("rnd_ovr",  64'(overrun), 64'(m_ov));

        z   = ($urandom_range(0, 99) < 30);
        w   = $urandom_range(0, 1) == 1;
        rdy = ($urandom_range(0, 99) < 60);
        res = {$urandom(), $urandom()};
        z_in = z; op_wide = w; result = res; bus.out_ready = rdy;

        pre = mq.size();
        if (pre > 0 && rdy) void'(mq.pop_front());
        if (z) begin
          if (pre == 0) begin
            beat_t b;
            b.d = res[31:0]; b.h = 1'b0;
            mq.push_back(b);
            if (w) begin
              b.d = res[63:32]; b.h = 1'b1;
              mq.push_back(b);
              m_hi = res[63:32];
              m_lo = res[31:0];
            end
          end else begin
            m_ov = 1'b1;
          end
        end
        @(negedge clock);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/z_result_unit.md
# z_result_unit

Capture stage directly downstream of the ALU in the Mini SRC datapath. Latches the ALU's 64-bit result into the Z register pair (ZHi/ZLo) on a load strobe, updates the HI/LO registers for wide (mul/div) operations, and drains the captured value onto the 32-bit bus as one or two beats under a valid/ready handshake. Decouples ALU evaluation from bus arbitration, so the control unit can move on while Z is written back.

## Interface
- No parameters; widths are fixed at a 64-bit result and a 32-bit bus.
- clock  in  1  system clock, all state updates on the rising edge
- clear  in  1  asynchronous, active-low reset
- z_in  in  1  load strobe; samples `result` when the unit is idle
- result  in  64  ALU result; {hi, lo}
- op_wide  in  1  sampled with `z_in`: 1 = mul/div (two beats, HI/LO update), 0 = single beat (lo only)
- out_ready  in  1  bus consumer accepts the current beat
- out_valid  out  1  beat available on `out_data`
- out_data  out  32  beat payload: ZLo on the first beat, ZHi on the second beat
- out_hi  out  1  1 when the current beat is ZHi
- busy  out  1  1 whenever the state is not IDLE
- hi_q  out  32  HI register
- lo_q  out  32  LO register
- overrun  out  1  sticky flag; set when `z_in` arrives while busy

## Operation
- States:
  - IDLE: no beat pending.
  - SEND_LO: `out_valid`=1, `out_data`=ZLo, `out_hi`=0.
  - SEND_HI: `out_valid`=1, `out_data`=ZHi, `out_hi`=1.
- IDLE with `z_in`=1:
  - ZHi←result[63:32], ZLo←result[31:0], wide←op_wide.
  - If `op_wide`=1, also HI←result[63:32] and LO←result[31:0].
  - Next state is SEND_LO.
- IDLE with `z_in`=0: remain in IDLE; all registers hold.
- SEND_LO:
  - On `out_valid`&`out_ready`: go to SEND_HI if wide=1, else go to IDLE.
  - Otherwise hold.
- SEND_HI:
  - On `out_valid`&`out_ready`: go to IDLE.
  - Otherwise hold.
- `z_in` while busy:
  - Z, HI, LO and wide are unchanged.
  - `overrun`←1; it clears only on reset.
- HI/LO change only on a wide capture. A narrow capture never disturbs them.
- No arithmetic is performed: values pass through bit-exact, with no sign extension or truncation beyond the hi/lo split.

## Timing
- Reset (`clear`=0, asynchronous): all outputs are 0 at reset.
  - State=IDLE.
  - ZHi, ZLo, HI, LO = 0.
  - `out_valid`, `out_data`, `out_hi`, `busy`, `overrun`, `hi_q`, `lo_q` = 0.
- `clear` asserted mid-transfer aborts immediately. The pending beat is lost and `out_valid` drops without waiting for a clock edge.
- All outputs are registered or decoded from registered state. There is no combinational path from `out_ready` or `z_in` to any output.
- Latency:
  - `z_in` sampled at edge N gives `out_valid`=1 with ZLo after N; `hi_q`/`lo_q` update at N as well.
  - Narrow with `out_ready` held at 1: one beat, IDLE after edge N+1.
  - Wide with `out_ready` held at 1: beats accepted at edges N+1 and N+2, IDLE after N+2.
- Handshake rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_hi` are stable.
  - `out_valid` never drops without a transfer, except on reset.
- Back-to-back: `z_in` is accepted only in IDLE. `z_in` on the same edge as the final transfer counts as busy and sets `overrun`. The earliest new capture is the edge after `busy` falls.
- Simultaneous `z_in` and reset: reset wins.

## Test plan
- Reset:
  - Stimulus: assert `clear`=0 mid-SEND_HI.
  - Response: `out_valid`, `busy`, `hi_q`, `lo_q` are 0 before the next edge; the unit resumes IDLE after release.
- Narrow OR result:
  - Stimulus: result=0x00000000_00000011, `op_wide`=0, `z_in` for one cycle, `out_ready`=1.
  - Response: one beat of 0x00000011 with `out_hi`=0; `hi_q`/`lo_q` remain 0; IDLE after 2 edges.
- Wide mul result with backpressure:
  - Stimulus: result=0x0000FFFF_0000F000, `op_wide`=1; `out_ready` held 0 for 3 cycles, then 1.
  - Response: beat 0x0000F000 held stable throughout the stall, then beat 0x0000FFFF with `out_hi`=1; `hi_q`=0x0000FFFF, `lo_q`=0x0000F000.
- Narrow after wide:
  - Stimulus: after the wide case, a narrow capture of result=0x12345678_9ABCDEF0.
  - Response: one beat of 0x9ABCDEF0; `hi_q`/`lo_q` still 0x0000FFFF/0x0000F000.
- Overrun:
  - Stimulus: `z_in` pulsed during SEND_LO with result=0xDEADBEEF_DEADBEEF.
  - Response: the beat in flight is unchanged; `overrun`=1 and stays 1 until reset.
- Back-to-back:
  - Stimulus: narrow capture, then a second `z_in` on the cycle after `busy` falls.
  - Response: both values are delivered in order, `overrun`=0.
